// File: rtl/up_counter_pkg.sv
// Shared definitions for the loadable up-counter: default width, next-state
// operation encoding and the all-ones terminal value helper.
package up_counter_pkg;

    localparam int UP_COUNTER_DEFAULT_WIDTH = 4;

    typedef enum logic {
        OP_INCR = 1'b0,
        OP_LOAD = 1'b1
    } op_e;

    // Widths above 64 are not supported by this helper.
    function automatic logic [63:0] terminal_value(input int width);
        return {64{1'b1}} >> (64 - width);
    endfunction

endpackage

// File: rtl/up_counter_tc.sv
// Terminal-count decoder: flags that the next counting edge will wrap to zero.
module up_counter_tc
    import up_counter_pkg::*;
#(
    parameter int WIDTH = UP_COUNTER_DEFAULT_WIDTH
) (
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(terminal_value(WIDTH));

    // Reset gating keeps tc low throughout reset, independent of q.
    always_comb begin
        tc = reset && !load_en && (q == TERMINAL);
    end

endmodule

// File: rtl/up_counter.sv
// Loadable wrap-around binary up-counter with asynchronous active-low reset.
// Define UP_COUNTER_TC_EN to add the terminal-count output tc after q.
module up_counter
    import up_counter_pkg::*;
#(
    parameter int DATA_WIDTH = UP_COUNTER_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
`ifdef UP_COUNTER_TC_EN
    ,
    output logic                  tc
`endif
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    op_e                   op;
    logic [DATA_WIDTH-1:0] count_d;
    logic [DATA_WIDTH-1:0] count_q;

    // Load wins over increment; the carry out of the increment is dropped.
    always_comb begin
        op      = load_en ? OP_LOAD : OP_INCR;
        count_d = count_q + ONE;
        if (op == OP_LOAD) begin
            count_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

`ifdef UP_COUNTER_TC_EN
    up_counter_tc #(
        .WIDTH(DATA_WIDTH)
    ) u_tc (
        .reset  (reset),
        .load_en(load_en),
        .q      (count_q),
        .tc     (tc)
    );
`endif

endmodule

// File: tb/tb_up_counter.sv
// Directed self-checking bench for up_counter (4-bit build).
module tb_up_counter;

    logic       clk;
    logic       reset;
    logic       load_en;
    logic [3:0] d;
    logic [3:0] q;
`ifdef UP_COUNTER_TC_EN
    logic       tc;
`endif

    int compared   = 0;
    int mismatched = 0;

    up_counter #(
        .DATA_WIDTH(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .load_en(load_en),
        .d      (d),
        .q      (q)
`ifdef UP_COUNTER_TC_EN
        ,
        .tc     (tc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive inputs away from the edge, take one rising edge, sample 1 ns later.
    task automatic applyStimulus(input logic le, input logic [3:0] dv);
        load_en = le;
        d       = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expq);
        compared++;
        assert (q === expq) else begin
            mismatched++;
            $error("[TB] FAIL %s: q=%h expected %h", tag, q, expq);
        end
    endtask

`ifdef UP_COUNTER_TC_EN
    task automatic checkTc(input string tag, input logic exptc);
        compared++;
        assert (tc === exptc) else begin
            mismatched++;
            $error("[TB] FAIL %s: tc=%b expected %b", tag, tc, exptc);
        end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        load_en = 1'b0;
        d       = 4'h0;

        // Reset held for two edges, then released into counting.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_async", 4'h0);
        applyStimulus(1'b0, 4'h0);
        checkOutput("reset_hold1", 4'h0);
        applyStimulus(1'b0, 4'h0);
        checkOutput("reset_hold2", 4'h0);
`ifdef UP_COUNTER_TC_EN
        checkTc("tc_in_reset", 1'b0);
`endif
        reset = 1'b1;
        applyStimulus(1'b0, 4'h0);
        checkOutput("release_1", 4'h1);
        applyStimulus(1'b0, 4'h0);
        checkOutput("release_2", 4'h2);
        applyStimulus(1'b0, 4'h0);
        checkOutput("release_3", 4'h3);

        // Load 2 then count.
        applyStimulus(1'b1, 4'h2);
        checkOutput("load_2", 4'h2);
        applyStimulus(1'b0, 4'h0);
        checkOutput("load_2_inc3", 4'h3);
        applyStimulus(1'b0, 4'h0);
        checkOutput("load_2_inc4", 4'h4);
        applyStimulus(1'b0, 4'h0);
        checkOutput("load_2_inc5", 4'h5);

        // Mid-cycle reset while q = 5.
        #3;
        reset = 1'b0;
        #1;
        checkOutput("midcycle_reset", 4'h0);
        applyStimulus(1'b0, 4'h0);
        checkOutput("midcycle_reset_hold", 4'h0);

        // Load request during reset is ignored; after release it loads.
        applyStimulus(1'b1, 4'hA);
        checkOutput("load_in_reset", 4'h0);
        reset = 1'b1;
        applyStimulus(1'b1, 4'hA);
        checkOutput("load_after_release", 4'hA);
        applyStimulus(1'b0, 4'hA);
        checkOutput("after_A_inc", 4'hB);

        // Load all-ones, then wrap.
        applyStimulus(1'b1, 4'hF);
        checkOutput("load_F", 4'hF);
`ifdef UP_COUNTER_TC_EN
        checkTc("tc_load_high", 1'b0);
`endif
        load_en = 1'b0;
        #1;
`ifdef UP_COUNTER_TC_EN
        checkTc("tc_at_F", 1'b1);
`endif
        applyStimulus(1'b0, 4'h0);
        checkOutput("wrap_0", 4'h0);
`ifdef UP_COUNTER_TC_EN
        checkTc("tc_after_wrap", 1'b0);
`endif
        applyStimulus(1'b0, 4'h0);
        checkOutput("wrap_1", 4'h1);

        // d changes without load_en must not disturb counting.
        applyStimulus(1'b0, 4'h7);
        checkOutput("d_ignored_2", 4'h2);
        applyStimulus(1'b0, 4'hC);
        checkOutput("d_ignored_3", 4'h3);
        applyStimulus(1'b0, 4'h9);
        checkOutput("d_ignored_4", 4'h4);

        // Back-to-back loads, then one increment.
        applyStimulus(1'b1, 4'h6);
        checkOutput("load_6", 4'h6);
        applyStimulus(1'b1, 4'hE);
        checkOutput("load_E", 4'hE);
        applyStimulus(1'b0, 4'h1);
        checkOutput("after_E_inc", 4'hF);
        applyStimulus(1'b0, 4'h1);
        checkOutput("natural_wrap", 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
